// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl
//   HD44780-class character LCD controller, 8-bit write-only bus, 2-line panel.
//   After reset it idles PWR_CYC cycles, sends the init sequence
//   (38, 0C, 01, 06, 80) and then drains a byte FIFO fed by a valid/ready
//   stream. Printable bytes are written as data. Newline (0x0A) and clear (0x0C)
//   are turned into LCD commands. All other bytes are dropped. The cursor is
//   tracked locally, and a line wrap re-addresses the panel.
// Ports
//   clk        system clock
//   rst        synchronous reset, active low
//   in_data    character/control byte
//   in_valid   in_data valid
//   in_ready   FIFO can accept (not full and init done)
//   lcd_db     LCD data bus
//   lcd_rs     0 = command, 1 = data
//   lcd_rw     always 0 (write only)
//   lcd_en     LCD enable strobe
//   init_done  init sequence complete
//   busy       transfer in progress or FIFO non-empty
//   cur_row    current cursor line
//   cur_col    current cursor column
module lcd_char_ctrl #(
  parameter int COLS       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int EN_CYC     = 100,
  parameter int CHR_CYC    = 100,
  parameter int CLR_CYC    = 2000,
  parameter int PWR_CYC    = 15000,
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    lcd_db,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic          init_done,
  output logic          busy,
  output logic          cur_row,
  output logic [CW-1:0] cur_col
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_PWR, S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;
  // What the byte currently on the bus was for; decides what HOLD does when it ends.
  typedef enum logic [2:0] {A_INIT, A_DATA, A_NL, A_CLR, A_ADDR} act_t;

  state_t      state;
  act_t        act;
  logic [31:0] cnt;
  logic [2:0]  init_idx;

  // Byte FIFO. Pointers have one extra bit so that full and empty can be told apart.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [7:0]  head;
  logic [31:0] hold_last;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign in_ready = !full && init_done;
  assign push     = in_valid && in_ready;
  // IDLE is only reachable after init. Every non-empty IDLE cycle consumes
  // the head, including the bytes that are discarded.
  assign pop      = (state == S_IDLE) && !empty;
  assign busy     = ((state != S_IDLE) && init_done) || !empty;
  assign lcd_rw   = 1'b0;

  // The clear-display command needs the long settle time.
  assign hold_last = (!lcd_rs && lcd_db == 8'h01) ? 32'(CLR_CYC - 1) : 32'(CHR_CYC - 1);

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      default: return 8'h80;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_PWR;
      act       <= A_INIT;
      cnt       <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      lcd_db    <= '0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      cur_row   <= 1'b0;
      cur_col   <= '0;
    end else begin
      case (state)
        S_PWR: begin
          if (cnt == 32'(PWR_CYC - 1)) begin
            cnt      <= '0;
            init_idx <= '0;
            act      <= A_INIT;
            lcd_db   <= init_byte(3'd0);
            lcd_rs   <= 1'b0;
            state    <= S_SETUP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (!empty) begin
            if (head >= 8'h20 && head <= 8'h7E) begin
              lcd_db <= head;
              lcd_rs <= 1'b1;
              act    <= A_DATA;
              state  <= S_SETUP;
            end else if (head == 8'h0A) begin
              // Address the start of the other line.
              lcd_db <= {1'b1, ~cur_row, 6'd0};
              lcd_rs <= 1'b0;
              act    <= A_NL;
              state  <= S_SETUP;
            end else if (head == 8'h0C) begin
              lcd_db <= 8'h01;
              lcd_rs <= 1'b0;
              act    <= A_CLR;
              state  <= S_SETUP;
            end
            // Any other byte is dropped by the pop alone.
          end
        end
        S_SETUP: begin
          lcd_en <= 1'b1;
          cnt    <= '0;
          state  <= S_STROBE;
        end
        S_STROBE: begin
          if (cnt == 32'(EN_CYC - 1)) begin
            lcd_en <= 1'b0;
            cnt    <= '0;
            state  <= S_HOLD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (cnt == hold_last) begin
            cnt <= '0;
            case (act)
              A_INIT: begin
                if (init_idx == 3'd4) begin
                  init_done <= 1'b1;
                  state     <= S_IDLE;
                end else begin
                  init_idx <= init_idx + 3'd1;
                  lcd_db   <= init_byte(init_idx + 3'd1);
                  state    <= S_SETUP;
                end
              end
              A_DATA: begin
                if (cur_col == CW'(COLS - 1)) begin
                  // A wrap re-addresses the panel before the next pop.
                  cur_col <= '0;
                  cur_row <= ~cur_row;
                  lcd_db  <= {1'b1, ~cur_row, 6'd0};
                  lcd_rs  <= 1'b0;
                  act     <= A_ADDR;
                  state   <= S_SETUP;
                end else begin
                  cur_col <= cur_col + CW'(1);
                  state   <= S_IDLE;
                end
              end
              A_NL: begin
                cur_col <= '0;
                cur_row <= ~cur_row;
                state   <= S_IDLE;
              end
              A_CLR: begin
                cur_col <= '0;
                cur_row <= 1'b0;
                state   <= S_IDLE;
              end
              default: state <= S_IDLE;
            endcase
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_PWR;
      endcase
    end
  end

endmodule
